// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_add_seq_pkg;

    // Width of one slice handed to the external carry-lookahead adder.
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/nibble_add_seq.sv
// Nibble-serial WIDTH-bit add/subtract sequencer. Operands are sliced into
// 4-bit nibbles and fed LSB-first to an external registered 4-bit adder.
// Each nibble's carry comes from the adder's registered cout, so every
// nibble takes two cycles: DRIVE (present inputs), then CAPTURE (collect).
// WIDTH must be a multiple of 4 and at least 4.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf,
    output logic [NIB_W-1:0] add_a,
    output logic [NIB_W-1:0] add_b,
    output logic             add_cin,
    input  logic [NIB_W-1:0] add_sum,
    input  logic             add_cout
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    seq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;        // already inverted when subtracting
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [NIB_W-1:0] add_a_q;
    logic [NIB_W-1:0] add_b_q;
    logic             add_cin_q;  // doubles as the chained carry register

    // Index of the nibble that follows the one being captured.
    always_comb begin
        idx_d = idx_q + 1'b1;
    end

    // Sequencer FSM; adder drive and handshake outputs are registered so they
    // change only on state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone accepts.
                    if (in_valid) begin
                        a_q        <= op_a;
                        b_q        <= op_b ^ {WIDTH{op_sub}};
                        idx_q      <= '0;
                        add_a_q    <= op_a[NIB_W-1:0];
                        add_b_q    <= op_b[NIB_W-1:0] ^ {NIB_W{op_sub}};
                        // Subtract is A + ~B + 1: the +1 enters as the first carry.
                        add_cin_q  <= op_sub;
                        in_ready_q <= 1'b0;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The adder registers its inputs on this edge; release the bus.
                    add_a_q   <= '0;
                    add_b_q   <= '0;
                    add_cin_q <= 1'b0;
                    state_q   <= CAPTURE;
                end
                CAPTURE: begin
                    result_q[idx_q*NIB_W +: NIB_W] <= add_sum;
                    if (idx_q == LAST_IDX) begin
                        carry_out_q <= add_cout;
                        // Signed overflow: operand signs agree but the sum's sign differs.
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (add_sum[NIB_W-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q     <= idx_d;
                        add_a_q   <= a_q[idx_d*NIB_W +: NIB_W];
                        add_b_q   <= b_q[idx_d*NIB_W +: NIB_W];
                        add_cin_q <= add_cout;
                        state_q   <= DRIVE;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; no timeout.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign ovf       = ovf_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Harness: nibble_add_seq plus a behavioural registered 4-bit adder, checked
// against a whole-word arithmetic reference model.
module tb_nibble_add_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .ovf       (ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Sibling registered 4-bit adder; its active-high reset is ~rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) {add_cout, add_sum} <= 5'd0;
        else        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 16-bit arithmetic and signed-range overflow test.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] r, output logic c, output logic o);
        int sa, sb, sr;
        logic [W:0] u;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            u  = {1'b0, a} - {1'b0, b};
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            c  = u[W];
            sr = sa + sb;
        end
        r = u[W-1:0];
        o = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_idle_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // One operation; hold = cycles out_ready is kept low once DONE is reached.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int hold, input string tag);
        logic [W-1:0] er;
        logic         ec, eo;
        int           n;
        model(a, b, sub, er, ec, eo);
        wait_idle(tag);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs to prove the operands were latched.
        in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_cout_ovf"}, {30'd0, carry_out, ovf}, {30'd0, ec, eo});
        chk({tag, "_done_bus"}, {22'd0, in_ready, add_a, add_b, add_cin}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a = W'($urandom); op_b = W'($urandom);
            @(negedge clk);
            chk($sformatf("%s_hold%0d", tag, i),
                {13'd0, out_valid, in_ready, result, carry_out, ovf},
                {13'd0, 1'b1, 1'b0, er, ec, eo});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {12'd0, out_valid, in_ready, result, carry_out, ovf},
            {12'd0, 1'b0, 1'b1, er, ec, eo});
    endtask

    initial begin
        logic [W-1:0] er;
        logic         ec, eo;
        int           t0, t1, n;
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", {10'd0, in_ready, out_valid, result, carry_out, ovf, add_a, add_b, add_cin},
            {10'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0});

        // Directed cases
        do_op(16'h1234, 16'h4321, 1'b0, 0, "add_5555");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, "add_ripple");
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf");
        do_op(16'h0005, 16'h0007, 1'b1, 0, "sub_neg");
        do_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
        do_op(16'hA5C3, 16'h1F2E, 1'b0, 5, "backpressure");

        // Back-to-back: in_valid held high, out_ready high -> 10 cycles per op
        wait_idle("b2b");
        op_a = 16'h0F0F; op_b = 16'h0101; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        model(16'h0F0F, 16'h0101, 1'b0, er, ec, eo);
        t0 = 0; t1 = 0; n = 0;
        while (t1 == 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                chk("b2b_result", 32'(result), 32'(er));
                if (t0 == 0) t0 = n;
                else begin
                    t1 = n;
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_period", 32'(t1 - t0), 32'd10);
        @(negedge clk);
        chk("b2b_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

        // Reset during CAPTURE of nibble 2
        wait_idle("rst");
        op_a = 16'h1234; op_b = 16'h4321; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_reset", {10'd0, in_ready, out_valid, result, carry_out, ovf, add_a, add_b, add_cin},
            {10'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0});
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("mid_reset_no_valid", 32'(n), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 0, "post_reset");

        // Randomized operations with random backpressure
        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
